gcd_engine: RTL and testbench
=============================

// Module: gcd_engine
// PURPOSE
//   Parametrised greatest-common-divisor engine with valid/ready handshakes on both sides.
//   Two run-time modes: subtractive Euclid and binary (Stein) GCD.
//   Adds an iteration counter, an optional iteration limit and a synchronous abort.
//   Serves as the shared arithmetic unit for the number-theory practice blocks.
// PARAMETERS
//   W         8   operand and result width, in bits
//   CNT_W     10  width of the iteration counter; saturates at all-ones
//   MAX_ITER  0   iteration limit; 0 = no limit, otherwise abort with res_err after MAX_ITER steps
// PORTS
//   clk        in   1      rising-edge clock
//   rst_n      in   1      asynchronous, active-low reset
//   in_valid   in   1      operands valid
//   in_ready   out  1      engine can accept; high only in IDLE
//   in_a       in   W      operand A
//   in_b       in   W      operand B
//   in_mode    in   1      0 = subtractive, 1 = binary; latched with the operands
//   abort      in   1      synchronous cancel of a job in progress
//   res_valid  out  1      result valid
//   res_ready  in   1      consumer accepts the result
//   res_gcd    out  W      GCD result; 0 when res_err=1
//   res_iters  out  CNT_W  number of reduction steps performed
//   res_err    out  1      iteration limit hit
//   busy       out  1      high in CALC
// BEHAVIOUR
//   Reset (async, rst_n=0): state=IDLE; in_ready=1; res_valid=0; res_gcd=0; res_iters=0;
//     res_err=0; busy=0; internal a, b, k and counter cleared.
//   FSM states: IDLE -> CALC -> DONE -> IDLE.
//   IDLE
//     - in_valid & in_ready at an edge: latch a=in_a, b=in_b, mode=in_mode; k=0; cnt=0; go to CALC.
//   CALC (one decision per clk)
//     - abort=1 has priority: go to IDLE; no result is produced.
//     - Termination test first: if a==0, b==0 or a==b, then
//       res_gcd=(a|b)<<k (truncated to W bits), res_iters=cnt, res_err=0; go to DONE.
//     - Else if MAX_ITER!=0 and cnt==MAX_ITER: res_gcd=0, res_iters=cnt, res_err=1; go to DONE.
//     - Else perform one step and increment cnt (saturating):
//       - mode 0: if a>b then a=a-b, else b=b-a.
//       - mode 1, first match wins:
//         - a and b both even: a>>=1, b>>=1, k++.
//         - a even: a>>=1.
//         - b even: b>>=1.
//         - a>b: a=(a-b)>>1.
//         - else: b=(b-a)>>1.
//   DONE
//     - res_valid=1; outputs stable while res_ready=0.
//     - res_valid & res_ready at an edge: res_valid=0; go to IDLE.
//     - abort is ignored in DONE.
//   Latency: accept at edge 0; n steps; res_valid rises after edge n+1.
//     With res_ready held high, the next operand is accepted at edge n+3.
//   Widths: a-b is never negative (guarded by the compare); shifts are logical.
//     Since a|b < 2^(W-k) at termination, the k shift never overflows W bits.
//   Zero inputs: gcd(0,x)=x and gcd(0,0)=0, both with 0 iterations.
//   in_a, in_b and in_mode are ignored when in_ready=0. res_* hold their last value outside DONE.
//   Reset mid-operation discards the job; the engine returns to IDLE immediately.
// TESTING
//   1. W=8, mode 0, A=12, B=8 -> res_gcd=4, res_iters=2, res_valid after edge 3.
//      Mode 1 with the same operands -> res_gcd=4, res_iters=4.
//   2. A=0, B=0 and A=0, B=9, both modes -> res_gcd=0 and 9 respectively, res_iters=0, res_err=0.
//   3. W=8, mode 0, A=255, B=1 -> res_gcd=1, res_iters=254.
//      Mode 1 with the same operands -> res_gcd=1, res_iters <= 2*W.
//   4. MAX_ITER=16, mode 0, A=255, B=1 -> res_err=1, res_gcd=0, res_iters=16.
//   5. Hold res_ready=0 for 5 cycles after res_valid -> outputs stable and in_ready=0;
//      the next job is accepted only after the res_valid & res_ready edge.
//   6. Mid-CALC abort pulse -> IDLE with res_valid never asserted.
//      Mid-CALC rst_n=0 -> all outputs at reset values with no clk edge; the next job computes correctly.

Source files
------------

// File: rtl/gcd_engine.sv
// gcd_engine: greatest-common-divisor engine with valid/ready handshakes on the
// operand and result sides. It supports two run-time modes, subtractive Euclid
// and binary (Stein). It also counts reduction steps, can enforce an optional
// iteration limit, and accepts a synchronous abort while a job is in progress.
module gcd_engine #(
  parameter int W        = 8,
  parameter int CNT_W    = 10,
  parameter int MAX_ITER = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_a,
  input  logic [W-1:0]     in_b,
  input  logic             in_mode,
  input  logic             abort,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [W-1:0]     res_gcd,
  output logic [CNT_W-1:0] res_iters,
  output logic             res_err,
  output logic             busy
);

  // k counts the common factors of two removed in binary mode; it never exceeds W.
  localparam int KW = $clog2(W + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [W-1:0]     a_q, a_d;
  logic [W-1:0]     b_q, b_d;
  logic [KW-1:0]    k_q, k_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             mode_q, mode_d;
  logic [W-1:0]     res_gcd_q, res_gcd_d;
  logic [CNT_W-1:0] res_iters_q, res_iters_d;
  logic             res_err_q, res_err_d;

  logic             finished;
  logic             limit_hit;
  logic             a_gt_b;
  logic [W-1:0]     diff_ab;
  logic [W-1:0]     diff_ba;

  // Shared comparisons and differences used by both reduction modes.
  always_comb begin
    finished  = (a_q == '0) || (b_q == '0) || (a_q == b_q);
    limit_hit = (MAX_ITER != 0) && (cnt_q == CNT_W'(MAX_ITER));
    a_gt_b    = a_q > b_q;
    diff_ab   = a_q - b_q;
    diff_ba   = b_q - a_q;
  end

  // Next-state logic: the operand handshake, one reduction step per cycle, and the result handshake.
  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    k_d         = k_q;
    cnt_d       = cnt_q;
    mode_d      = mode_q;
    res_gcd_d   = res_gcd_q;
    res_iters_d = res_iters_q;
    res_err_d   = res_err_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = in_a;
          b_d     = in_b;
          mode_d  = in_mode;
          k_d     = '0;
          cnt_d   = '0;
          state_d = CALC;
        end
      end

      CALC: begin
        if (abort) begin
          state_d = IDLE;
        end else if (finished) begin
          res_gcd_d   = (a_q | b_q) << k_q;
          res_iters_d = cnt_q;
          res_err_d   = 1'b0;
          state_d     = DONE;
        end else if (limit_hit) begin
          res_gcd_d   = '0;
          res_iters_d = cnt_q;
          res_err_d   = 1'b1;
          state_d     = DONE;
        end else begin
          if (cnt_q != '1) begin
            cnt_d = cnt_q + CNT_W'(1);
          end
          if (!mode_q) begin
            if (a_gt_b) begin
              a_d = diff_ab;
            end else begin
              b_d = diff_ba;
            end
          end else if (!a_q[0] && !b_q[0]) begin
            a_d = a_q >> 1;
            b_d = b_q >> 1;
            k_d = k_q + KW'(1);
          end else if (!a_q[0]) begin
            a_d = a_q >> 1;
          end else if (!b_q[0]) begin
            b_d = b_q >> 1;
          end else if (a_gt_b) begin
            a_d = diff_ab >> 1;
          end else begin
            b_d = diff_ba >> 1;
          end
        end
      end

      DONE: begin
        if (res_ready) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset discards any job in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      k_q         <= '0;
      cnt_q       <= '0;
      mode_q      <= 1'b0;
      res_gcd_q   <= '0;
      res_iters_q <= '0;
      res_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      k_q         <= k_d;
      cnt_q       <= cnt_d;
      mode_q      <= mode_d;
      res_gcd_q   <= res_gcd_d;
      res_iters_q <= res_iters_d;
      res_err_q   <= res_err_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q == CALC);
  assign res_valid = (state_q == DONE);
  assign res_gcd   = res_gcd_q;
  assign res_iters = res_iters_q;
  assign res_err   = res_err_q;

endmodule

// File: tb/tb_gcd_engine.sv
// tb_gcd_engine: randomized and directed checks of gcd_engine against a
// behavioural reference model. A second instance carries an iteration limit.
module tb_gcd_engine;

  localparam int W     = 8;
  localparam int CNT_W = 10;
  localparam int LIM   = 16;

  logic clk = 1'b0;
  logic rst_n;

  // Signals for the unlimited instance.
  logic             in_valid, in_ready, in_mode, abort;
  logic [W-1:0]     in_a, in_b;
  logic             res_valid, res_ready, res_err, busy;
  logic [W-1:0]     res_gcd;
  logic [CNT_W-1:0] res_iters;

  // Signals for the instance limited to LIM steps.
  logic             l_in_valid, l_in_ready, l_in_mode, l_abort;
  logic [W-1:0]     l_in_a, l_in_b;
  logic             l_res_valid, l_res_ready, l_res_err, l_busy;
  logic [W-1:0]     l_res_gcd;
  logic [CNT_W-1:0] l_res_iters;

  int vecCount = 0;
  int errCount = 0;

  // Free-running clock with a 10-unit period.
  always #5 clk = ~clk;

  gcd_engine #(.W(W), .CNT_W(CNT_W), .MAX_ITER(0)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_mode(in_mode), .abort(abort),
    .res_valid(res_valid), .res_ready(res_ready), .res_gcd(res_gcd),
    .res_iters(res_iters), .res_err(res_err), .busy(busy)
  );

  gcd_engine #(.W(W), .CNT_W(CNT_W), .MAX_ITER(LIM)) dut_lim (
    .clk(clk), .rst_n(rst_n), .in_valid(l_in_valid), .in_ready(l_in_ready),
    .in_a(l_in_a), .in_b(l_in_b), .in_mode(l_in_mode), .abort(l_abort),
    .res_valid(l_res_valid), .res_ready(l_res_ready), .res_gcd(l_res_gcd),
    .res_iters(l_res_iters), .res_err(l_res_err), .busy(l_busy)
  );

  // Single comparison point: counts each vector and reports any miscompare.
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vecCount++;
    if (observed !== expected) begin
      errCount++;
      $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // Mathematical GCD by repeated remainder, independent of the engine's step rules.
  function automatic int gcdMod(input int a, input int b);
    int x, y, t;
    x = a;
    y = b;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  // Reference model: counts reduction steps with plain integer arithmetic.
  // The result comes from gcdMod, or is 0 when the step limit is reached.
  function automatic void refModel(input int a, input int b, input int mode, input int maxIter,
                                   output int g, output int n, output int err);
    int x, y;
    x   = a;
    y   = b;
    n   = 0;
    err = 0;
    while (!(x == 0 || y == 0 || x == y)) begin
      if (maxIter != 0 && n == maxIter) begin
        err = 1;
        break;
      end
      if (mode == 0) begin
        if (x > y) x = x - y;
        else       y = y - x;
      end else if (x % 2 == 0 && y % 2 == 0) begin
        x = x / 2;
        y = y / 2;
      end else if (x % 2 == 0) begin
        x = x / 2;
      end else if (y % 2 == 0) begin
        y = y / 2;
      end else if (x > y) begin
        x = (x - y) / 2;
      end else begin
        y = (y - x) / 2;
      end
      n++;
    end
    g = err ? 0 : gcdMod(a, b);
  endfunction

  // Runs one job on the unlimited instance. Before releasing the result it holds
  // res_ready low for 'hold' cycles after res_valid rises.
  task automatic applyStimulus(input int a, input int b, input int mode, input int hold, input string tag);
    int g, n, e, cycles;
    refModel(a, b, mode, 0, g, n, e);
    @(negedge clk);
    checkOutput({tag, ".inReady"}, 32'(in_ready), 32'd1);
    in_a      = W'(a);
    in_b      = W'(b);
    in_mode   = mode[0];
    in_valid  = 1'b1;
    res_ready = (hold == 0);
    @(negedge clk);
    in_valid = 1'b0;
    cycles   = 0;
    while (!res_valid && cycles < 1000) begin
      @(negedge clk);
      cycles++;
    end
    checkOutput({tag, ".latency"}, 32'(cycles), 32'(n + 1));
    checkOutput({tag, ".gcd"}, 32'(res_gcd), 32'(g));
    checkOutput({tag, ".iters"}, 32'(res_iters), 32'(n));
    checkOutput({tag, ".err"}, 32'(res_err), 32'(e));
    checkOutput({tag, ".busyLow"}, 32'(busy), 32'd0);
    checkOutput({tag, ".inReadyLow"}, 32'(in_ready), 32'd0);
    if (mode == 1) begin
      checkOutput({tag, ".binBound"}, 32'(res_iters <= CNT_W'(2 * W)), 32'd1);
    end
    if (hold > 0) begin
      repeat (hold) begin
        @(negedge clk);
        checkOutput({tag, ".holdValid"}, 32'(res_valid), 32'd1);
        checkOutput({tag, ".holdGcd"}, 32'(res_gcd), 32'(g));
        checkOutput({tag, ".holdIters"}, 32'(res_iters), 32'(n));
        checkOutput({tag, ".holdInReady"}, 32'(in_ready), 32'd0);
      end
      res_ready = 1'b1;
    end
    @(negedge clk);
    checkOutput({tag, ".validDrop"}, 32'(res_valid), 32'd0);
    checkOutput({tag, ".readyBack"}, 32'(in_ready), 32'd1);
  endtask

  // Runs one job on the iteration-limited instance.
  task automatic applyLimited(input int a, input int b, input int mode, input string tag);
    int g, n, e, cycles;
    refModel(a, b, mode, LIM, g, n, e);
    @(negedge clk);
    l_in_a     = W'(a);
    l_in_b     = W'(b);
    l_in_mode  = mode[0];
    l_in_valid = 1'b1;
    @(negedge clk);
    l_in_valid = 1'b0;
    cycles     = 0;
    while (!l_res_valid && cycles < 1000) begin
      @(negedge clk);
      cycles++;
    end
    checkOutput({tag, ".latency"}, 32'(cycles), 32'(n + 1));
    checkOutput({tag, ".gcd"}, 32'(l_res_gcd), 32'(g));
    checkOutput({tag, ".iters"}, 32'(l_res_iters), 32'(n));
    checkOutput({tag, ".err"}, 32'(l_res_err), 32'(e));
    @(negedge clk);
    checkOutput({tag, ".validDrop"}, 32'(l_res_valid), 32'd0);
  endtask

  // Checks every output against its reset value.
  task automatic checkResetState(input string tag);
    checkOutput({tag, ".inReady"}, 32'(in_ready), 32'd1);
    checkOutput({tag, ".resValid"}, 32'(res_valid), 32'd0);
    checkOutput({tag, ".resGcd"}, 32'(res_gcd), 32'd0);
    checkOutput({tag, ".resIters"}, 32'(res_iters), 32'd0);
    checkOutput({tag, ".resErr"}, 32'(res_err), 32'd0);
    checkOutput({tag, ".busy"}, 32'(busy), 32'd0);
  endtask

  // Main sequence: reset, directed cases, limit, hold, abort, mid-job reset, random jobs.
  initial begin
    bit sawValid;
    int ra, rb;

    rst_n       = 1'b0;
    in_valid    = 1'b0;
    in_a        = '0;
    in_b        = '0;
    in_mode     = 1'b0;
    abort       = 1'b0;
    res_ready   = 1'b1;
    l_in_valid  = 1'b0;
    l_in_a      = '0;
    l_in_b      = '0;
    l_in_mode   = 1'b0;
    l_abort     = 1'b0;
    l_res_ready = 1'b1;
    #1;
    checkResetState("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    applyStimulus(12, 8, 0, 0, "sub12_8");
    applyStimulus(12, 8, 1, 0, "bin12_8");
    applyStimulus(0, 0, 0, 0, "sub0_0");
    applyStimulus(0, 0, 1, 0, "bin0_0");
    applyStimulus(0, 9, 0, 0, "sub0_9");
    applyStimulus(0, 9, 1, 0, "bin0_9");
    applyStimulus(9, 0, 1, 0, "bin9_0");
    applyStimulus(255, 1, 0, 0, "sub255_1");
    applyStimulus(255, 1, 1, 0, "bin255_1");
    applyStimulus(128, 64, 1, 0, "bin128_64");
    applyStimulus(36, 24, 1, 5, "holdBin");
    applyStimulus(200, 150, 0, 3, "holdSub");

    applyLimited(255, 1, 0, "limSub255_1");
    applyLimited(12, 8, 1, "limBin12_8");
    applyLimited(255, 1, 1, "limBin255_1");
    applyLimited(17, 16, 0, "limSub17_16");

    // Abort in the middle of a long subtractive job.
    @(negedge clk);
    in_a     = 8'd255;
    in_b     = 8'd1;
    in_mode  = 1'b0;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    checkOutput("abort.busyBefore", 32'(busy), 32'd1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checkOutput("abort.inReady", 32'(in_ready), 32'd1);
    checkOutput("abort.busy", 32'(busy), 32'd0);
    sawValid = 1'b0;
    repeat (300) begin
      @(negedge clk);
      if (res_valid) sawValid = 1'b1;
    end
    checkOutput("abort.noResult", 32'(sawValid), 32'd0);
    applyStimulus(48, 18, 0, 0, "postAbort");

    // Reset asserted mid-cycle while a job is in progress.
    @(negedge clk);
    in_a     = 8'd255;
    in_b     = 8'd1;
    in_mode  = 1'b0;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkResetState("midReset");
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(255, 1, 0, 0, "postReset");

    // Random jobs, with zeros and small values mixed in.
    for (int i = 0; i < 60; i++) begin
      ra = int'($urandom_range(0, 255));
      rb = int'($urandom_range(0, 255));
      if ($urandom_range(0, 9) == 0) ra = 0;
      if ($urandom_range(0, 9) == 0) rb = int'($urandom_range(0, 7));
      applyStimulus(ra, rb, int'($urandom_range(0, 1)), int'($urandom_range(0, 2)), "rand");
    end
    for (int i = 0; i < 10; i++) begin
      applyLimited(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                   int'($urandom_range(0, 1)), "randLim");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
    $finish;
  end

endmodule
